pompa_surucu: RTL
=================

# pompa_surucu

Motor-side receiver for the irrigation watering command. It takes the raw motor-request level produced by the watering timer, synchronises and debounces it, and drives the pump enable. It enforces a minimum rest time between runs and a maximum continuous run time, which latches a fault. It also drives run/idle indicator LEDs and counts completed watering starts. It sits between the watering timer and the pump relay driver.

## Interface
- `DEBOUNCE_CYC`, default 500000: consecutive cycles a new request level must hold before it is accepted; ≥1.
- `MIN_OFF_CYC`, default 250000000: minimum motor-off cycles after reset, after any run, and after fault clear; ≥1.
- `MAX_ON_CYC`, default 1500000000: maximum continuous motor-on cycles before fault; ≥1.
- `clk` in 1: system clock (50 MHz).
- `rst` in 1: synchronous, active-high reset.
- `req_in` in 1: raw watering request, 1 = pump requested; asynchronous to `clk`.
- `fault_clr` in 1: single-cycle fault acknowledge.
- `motor_en` out 1: pump relay enable, 1 = pump on.
- `runLED` out 1: 1 while `motor_en` = 1.
- `idleLED` out 1: 1 while the motor is off and no fault is latched.
- `fault` out 1: latched over-run fault.
- `start_count` out 16: number of RUN entries since reset; saturates at 0xFFFF.

## Operation
- **Input synchroniser:** two-flop synchroniser `req_in` → `s1` → `s2`. Both flops reset to 0.
- **Debounce:** `req_stable` resets to 0, `dcnt` resets to 0.
  - If `s2 == req_stable`: `dcnt` ← 0.
  - Else if `dcnt == DEBOUNCE_CYC-1`: `req_stable` ← `s2` and `dcnt` ← 0.
  - Else: `dcnt` increments.
  - A level held fewer than `DEBOUNCE_CYC` cycles at `s2` is rejected.
- **State machine:** states HOLDOFF, IDLE, RUN, FAULT. Reset state is HOLDOFF with `tcnt` = 0. `tcnt` is 32 bits, reset on every state change, otherwise incremented.
  - **HOLDOFF:** when `tcnt == MIN_OFF_CYC-1` → IDLE. `req_stable` is ignored here.
  - **IDLE:** if `req_stable` = 1 → RUN, and `start_count` increments (saturating).
  - **RUN:** if `req_stable` = 0 → HOLDOFF. Else if `tcnt == MAX_ON_CYC-1` → FAULT. If both conditions hold in the same cycle, the request drop wins (→ HOLDOFF, no fault).
  - **FAULT:** leaves only when `fault_clr` = 1 and `req_stable` = 0 in the same cycle → HOLDOFF. `fault_clr` while `req_stable` = 1 is ignored. `fault_clr` in any other state has no effect.
- **Outputs:** all registered, decoded from the next state so that they change on the same edge as the state.
  - `motor_en` = (state == RUN)
  - `runLED` = `motor_en`
  - `fault` = (state == FAULT)
  - `idleLED` = ~`motor_en` & ~`fault`
- **Reset values:** `motor_en` = 0, `runLED` = 0, `idleLED` = 1, `fault` = 0, `start_count` = 0.
- **Reset mid-run:** `rst` asserted during RUN drops `motor_en` on the next edge and restarts the full `MIN_OFF_CYC` hold-off.

## Timing
- `req_in` rise settled before edge 0 with the FSM in IDLE:
  - `req_stable` = 1 after edge `DEBOUNCE_CYC+1`.
  - `motor_en` = 1 after edge `DEBOUNCE_CYC+2`.
  - Falling request has the same latency to `motor_en` = 0.
- Request arriving during HOLDOFF: `motor_en` rises on the edge following the HOLDOFF→IDLE edge, provided `req_stable` is already 1.
- Hold-off length is exactly `MIN_OFF_CYC` cycles.
- Maximum run is exactly `MAX_ON_CYC` cycles of `motor_en` = 1. `fault` rises on the same edge that `motor_en` falls.
- Fault clear: `fault_clr` sampled with `req_stable` = 0 → `fault` = 0 after that edge, followed by a full hold-off.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYC`=4, `MIN_OFF_CYC`=10, `MAX_ON_CYC`=20.

1. **Reset/hold-off:** release `rst`, hold `req_in`=1 → `motor_en` stays 0 for 10 cycles, then rises on the edge after HOLDOFF→IDLE; `start_count`=1.
2. **Glitch reject:** from IDLE, pulse `req_in`=1 for 3 cycles → `motor_en` never rises, `start_count` unchanged. A 4-cycle pulse is accepted (`req_stable` rises), after which `motor_en` rises and `start_count` increments.
3. **Normal cycle:** from IDLE, `req_in`=1 for 15 cycles, then 0 → `motor_en` high 15 cycles, starting 6 edges after the rise; HOLDOFF lasts 10 cycles; `idleLED`=1 throughout; `fault`=0.
4. **Over-run:** from IDLE, `req_in`=1 held → `motor_en` high exactly 20 cycles, then `fault`=1 and `idleLED`=0. `fault_clr` while `req_in`=1 → still FAULT. Drop `req_in`, wait 6 cycles, pulse `fault_clr` → `fault`=0, then 10-cycle hold-off.
5. **Simultaneous drop/timeout:** time the `req_stable` fall to the cycle where `tcnt`=19 → HOLDOFF entered, `fault` stays 0.
6. **Saturation/reset:** preload-force `start_count`=0xFFFF, run one more cycle → stays 0xFFFF. Assert `rst` mid-RUN → `motor_en`=0 next edge, `start_count`=0.

Source files
------------

// File: rtl/pompa_surucu.sv
// Pump driver: synchronises and debounces the watering request, then runs the pump under hold-off / over-run rules.
// Latency: with the FSM in IDLE, a settled request edge reaches motor_en DEBOUNCE_CYC+2 edges after the first edge that samples it.
// Backpressure: none; this is a level-driven control path that samples every cycle and never stalls.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   req_in        raw watering request from the timer (asynchronous to clk)
//   fault_clr     single-cycle fault acknowledge
//   motor_en      pump relay enable
//   runLED        lit while the pump runs
//   idleLED       lit while the pump is off and no fault is latched
//   fault         latched over-run fault
//   start_count   number of pump starts since reset, saturating at 0xFFFF
module pompa_surucu #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned MIN_OFF_CYC  = 250000000,
  parameter int unsigned MAX_ON_CYC   = 1500000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_in,
  input  logic        fault_clr,
  output logic        motor_en,
  output logic        runLED,
  output logic        idleLED,
  output logic        fault,
  output logic [15:0] start_count
);

  // Terminal counts; each counter matches on "last cycle" so a value N gives exactly N cycles.
  localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYC - 1);
  localparam logic [31:0] OFF_LAST = 32'(MIN_OFF_CYC - 1);
  localparam logic [31:0] ON_LAST  = 32'(MAX_ON_CYC - 1);

  typedef enum logic [1:0] {
    HOLDOFF = 2'd0,
    IDLE    = 2'd1,
    RUN     = 2'd2,
    FAULT   = 2'd3
  } state_t;

  // --------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous request level
  // --------------------------------------------------------------------
  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= req_in;
      s2 <= s1;
    end
  end

  // --------------------------------------------------------------------
  // Debounce: a new level must be seen at s2 for DEBOUNCE_CYC consecutive
  // cycles before it replaces req_stable. Any return to the current
  // stable level restarts the count.
  // --------------------------------------------------------------------
  logic        req_stable;
  logic [31:0] dcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_stable <= 1'b0;
      dcnt       <= 32'd0;
    end else if (s2 == req_stable) begin
      dcnt <= 32'd0;
    end else if (dcnt == DB_LAST) begin
      req_stable <= s2;
      dcnt       <= 32'd0;
    end else begin
      dcnt <= dcnt + 32'd1;
    end
  end

  // --------------------------------------------------------------------
  // Next-state decode
  // --------------------------------------------------------------------
  state_t      state;
  state_t      state_nxt;
  logic [31:0] tcnt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      HOLDOFF: begin
        // The request is deliberately ignored until the rest time is over.
        if (tcnt == OFF_LAST) state_nxt = IDLE;
      end
      IDLE: begin
        if (req_stable) state_nxt = RUN;
      end
      RUN: begin
        // A request drop takes priority over a coincident timeout, so a
        // run that ends on its very last allowed cycle is not a fault.
        if (!req_stable)           state_nxt = HOLDOFF;
        else if (tcnt == ON_LAST)  state_nxt = FAULT;
      end
      FAULT: begin
        // Clearing while the timer still asks for water would restart the
        // pump into the same over-run, so the request must be gone first.
        if (fault_clr && !req_stable) state_nxt = HOLDOFF;
      end
      default: state_nxt = HOLDOFF;
    endcase
  end

  // --------------------------------------------------------------------
  // State, timer and registered outputs. Outputs decode state_nxt so they
  // switch on the same edge as the state itself.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLDOFF;
      tcnt        <= 32'd0;
      motor_en    <= 1'b0;
      runLED      <= 1'b0;
      idleLED     <= 1'b1;
      fault       <= 1'b0;
      start_count <= 16'd0;
    end else begin
      state <= state_nxt;

      // Timer measures time spent in the current state.
      if (state_nxt != state) tcnt <= 32'd0;
      else                    tcnt <= tcnt + 32'd1;

      motor_en <= (state_nxt == RUN);
      runLED   <= (state_nxt == RUN);
      fault    <= (state_nxt == FAULT);
      idleLED  <= (state_nxt != RUN) && (state_nxt != FAULT);

      if (state == IDLE && state_nxt == RUN && start_count != 16'hFFFF)
        start_count <= start_count + 16'd1;
    end
  end

endmodule
